alu_issue_scheduler: RTL and testbench

- Shares one `alu_optimized` instance between two requesters: port 0 is the EX pipeline and port 1 is the address-gen/CSR helper.
- Arbitrates round-robin and drives the ALU operand and op lines, holding them stable for the op's latency class.
- Waits for the ALU's fast_ready or slow_ready flag, then returns the result, tagged with the requester id, through a valid/ready response port.
- Sits between the decode/issue logic and the ALU datapath.

---
 rtl/mincpu_alu_pkg.sv | 22 ++
 rtl/rr_arbiter2.sv | 26 ++
 rtl/alu_issue_scheduler.sv | 158 +++++++++++++++
 tb/tb_alu_issue_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mincpu_alu_pkg.sv
// Shared ALU op encodings, op latency classing and scheduler state type.
package mincpu_alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} sched_state_t;

  // Shifts and compares use the slow path; unassigned codes 1010-1111 stay fast.
  function automatic logic is_slow_op(input logic [3:0] op);
    return (op >= ALU_SLL) && (op <= ALU_SLTU);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant when enabled.
// Latency: combinational grant and next pointer.
// Backpressure: en=0 suppresses all grants and holds the pointer.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  input  logic       en,
  output logic [1:0] grant,
  output logic       next_ptr
);

  always_comb begin
    grant    = 2'b00;
    next_ptr = rr_ptr;
    if (en) begin
      if (&req) begin
        // Contention: pointer picks the winner and then points at the loser.
        grant[rr_ptr] = 1'b1;
        next_ptr      = ~rr_ptr;
      end else begin
        grant = req;
      end
    end
  end

endmodule

// File: rtl/alu_issue_scheduler.sv
// Shares one ALU between two requesters; ALU_SCHED_TIMEOUT_EN adds a watchdog.
// Latency: class_cycles edges from accept to rsp_valid when the ALU flag is ready.
// Backpressure: requests only granted in IDLE or in DONE while rsp_ready=1.
module alu_issue_scheduler
  import mincpu_alu_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int FAST_CYCLES    = 1,
  parameter int SLOW_CYCLES    = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_op,
  input  logic [DATA_W-1:0] req0_src1,
  input  logic [DATA_W-1:0] req0_src2,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_op,
  input  logic [DATA_W-1:0] req1_src1,
  input  logic [DATA_W-1:0] req1_src2,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  input  logic              alu_fast_ready,
  input  logic              alu_slow_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
`ifdef ALU_SCHED_TIMEOUT_EN
  output logic              timeout_err,
`endif
  output logic              busy
);

  localparam int MAX_CYC = (FAST_CYCLES > SLOW_CYCLES) ? FAST_CYCLES : SLOW_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] FAST_LD = CNT_W'(FAST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOW_LD = CNT_W'(SLOW_CYCLES - 1);

  sched_state_t      state;
  logic [CNT_W-1:0]  cnt;
  logic              id_q;
  logic              rr_ptr;
  logic [1:0]        grant;
  logic              next_ptr;
  logic              grant_en;
  logic              grant_id;
  logic [3:0]        sel_op;
  logic [DATA_W-1:0] sel_src1;
  logic [DATA_W-1:0] sel_src2;
  logic              flag_ok;

`ifdef ALU_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd;
`endif

  // Gating with rst_n keeps both ready lines low while reset is held.
  assign grant_en = rst_n && ((state == IDLE) || ((state == DONE) && rsp_ready));

  rr_arbiter2 u_arb (
    .req      ({req1_valid, req0_valid}),
    .rr_ptr   (rr_ptr),
    .en       (grant_en),
    .grant    (grant),
    .next_ptr (next_ptr)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign grant_id   = grant[1];
  assign sel_op     = grant_id ? req1_op   : req0_op;
  assign sel_src1   = grant_id ? req1_src1 : req0_src1;
  assign sel_src2   = grant_id ? req1_src2 : req0_src2;
  assign flag_ok    = is_slow_op(alu_op) ? alu_slow_ready : alu_fast_ready;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      id_q       <= 1'b0;
      rr_ptr     <= 1'b0;
      alu_op     <= 4'b0000;
      alu_src1   <= '0;
      alu_src2   <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
`ifdef ALU_SCHED_TIMEOUT_EN
      timeout_err <= 1'b0;
      wd          <= '0;
`endif
    end else begin
      case (state)
        EXEC: begin
`ifdef ALU_SCHED_TIMEOUT_EN
          wd <= wd + WD_W'(1);
`endif
          if ((cnt == '0) && flag_ok) begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            rsp_id     <= id_q;
            rsp_valid  <= 1'b1;
            state      <= DONE;
          end
`ifdef ALU_SCHED_TIMEOUT_EN
          else if (wd == WD_LAST) begin
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_id      <= id_q;
            rsp_valid   <= 1'b1;
            timeout_err <= 1'b1;
            state       <= DONE;
          end
`endif
          else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
`ifdef ALU_SCHED_TIMEOUT_EN
            timeout_err <= 1'b0;
`endif
            state     <= IDLE;
          end
        end
        default: ;
      endcase

      // Accept overrides the IDLE fall-through above, giving back-to-back issue from DONE.
      if (|grant) begin
        alu_op   <= sel_op;
        alu_src1 <= sel_src1;
        alu_src2 <= sel_src2;
        id_q     <= grant_id;
        rr_ptr   <= next_ptr;
        cnt      <= is_slow_op(sel_op) ? SLOW_LD : FAST_LD;
        state    <= EXEC;
`ifdef ALU_SCHED_TIMEOUT_EN
        wd       <= '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Directed bench for alu_issue_scheduler; the bench plays the ALU by driving result/flags.
module tb_alu_issue_scheduler;
  import mincpu_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op, alu_op;
  logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
  logic [31:0] alu_src1, alu_src2, alu_result, rsp_result;
  logic        alu_zero, alu_fast_ready, alu_slow_ready;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
`ifdef ALU_SCHED_TIMEOUT_EN
  logic        timeout_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req0_valid     (req0_valid),
    .req0_ready     (req0_ready),
    .req0_op        (req0_op),
    .req0_src1      (req0_src1),
    .req0_src2      (req0_src2),
    .req1_valid     (req1_valid),
    .req1_ready     (req1_ready),
    .req1_op        (req1_op),
    .req1_src1      (req1_src1),
    .req1_src2      (req1_src2),
    .alu_op         (alu_op),
    .alu_src1       (alu_src1),
    .alu_src2       (alu_src2),
    .alu_result     (alu_result),
    .alu_zero       (alu_zero),
    .alu_fast_ready (alu_fast_ready),
    .alu_slow_ready (alu_slow_ready),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_id         (rsp_id),
    .rsp_result     (rsp_result),
    .rsp_zero       (rsp_zero),
`ifdef ALU_SCHED_TIMEOUT_EN
    .timeout_err    (timeout_err),
`endif
    .busy           (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_op = ALU_ADD; req0_src1 = '0; req0_src2 = '0;
    req1_valid = 1'b0; req1_op = ALU_ADD; req1_src1 = '0; req1_src2 = '0;
    alu_result = '0; alu_zero = 1'b0;
    alu_fast_ready = 1'b1; alu_slow_ready = 1'b0; rsp_ready = 1'b1;

    // Reset values, including ready held low despite a pending request.
    #12;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_src1", alu_src1, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_req0_ready", req0_ready, 0);
    req0_valid = 1'b0;
    #1 rst_n = 1'b1;
    tick();

    // 1: single fast ADD.
    req0_valid = 1'b1; req0_op = ALU_ADD;
    req0_src1 = 32'h12345678; req0_src2 = 32'h87654321;
    alu_result = 32'h99999999; alu_zero = 1'b0;
    #1;
    chk("t1_req0_ready", req0_ready, 1);
    chk("t1_req1_ready", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("t1_req0_ready_drop", req0_ready, 0);
    chk("t1_busy", busy, 1);
    chk("t1_alu_src1", alu_src1, 32'h12345678);
    chk("t1_alu_src2", alu_src2, 32'h87654321);
    tick();
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_result", rsp_result, 32'h99999999);
    chk("t1_rsp_zero", rsp_zero, 0);
    chk("t1_rsp_id", rsp_id, 0);
    tick();
    chk("t1_idle_rsp_valid", rsp_valid, 0);
    chk("t1_idle_busy", busy, 0);

    // 2: slow SLL from requester 1 with slow_ready late.
    req1_valid = 1'b1; req1_op = ALU_SLL; req1_src1 = 32'h1; req1_src2 = 32'h4;
    alu_result = 32'h10;
    #1;
    chk("t2_req1_ready", req1_ready, 1);
    tick();
    req1_valid = 1'b0; req1_src1 = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      chk("t2_wait_rsp_valid", rsp_valid, 0);
      chk("t2_alu_op_stable", alu_op, ALU_SLL);
      chk("t2_alu_src1_stable", alu_src1, 32'h1);
      chk("t2_alu_src2_stable", alu_src2, 32'h4);
      tick();
    end
    chk("t2_still_waiting", rsp_valid, 0);
    alu_slow_ready = 1'b1;
    tick();
    alu_slow_ready = 1'b0;
    chk("t2_rsp_valid", rsp_valid, 1);
    chk("t2_rsp_id", rsp_id, 1);
    chk("t2_rsp_result", rsp_result, 32'h10);
    tick();
    chk("t2_idle", busy, 0);

    // 3: contention with XOR; grants alternate and DONE chains straight into EXEC.
    req0_valid = 1'b1; req0_op = ALU_XOR; req0_src1 = 32'hAAAA5555; req0_src2 = 32'h5555AAAA;
    req1_valid = 1'b1; req1_op = ALU_XOR; req1_src1 = 32'hAAAA5555; req1_src2 = 32'h5555AAAA;
    alu_result = 32'hFFFFFFFF;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("t3_grant0", req0_ready, (i % 2 == 0) ? 1 : 0);
      chk("t3_grant1", req1_ready, (i % 2 == 1) ? 1 : 0);
      tick();
      chk("t3_exec_busy", busy, 1);
      chk("t3_exec_no_rsp", rsp_valid, 0);
      chk("t3_exec_no_ready", {req1_ready, req0_ready}, 0);
      tick();
      chk("t3_rsp_valid", rsp_valid, 1);
      chk("t3_rsp_id", rsp_id, i % 2);
      chk("t3_rsp_result", rsp_result, 32'hFFFFFFFF);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("t3_idle", busy, 0);

    // 4: response backpressure on SUB.
    req0_valid = 1'b1; req0_op = ALU_SUB; req0_src1 = 32'h87654321; req0_src2 = 32'h12345678;
    alu_result = 32'h7530ECA9; rsp_ready = 1'b0;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b1; req1_op = ALU_ADD;
    tick();
    alu_result = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      chk("t4_rsp_valid_held", rsp_valid, 1);
      chk("t4_rsp_result_held", rsp_result, 32'h7530ECA9);
      chk("t4_no_ready", {req1_ready, req0_ready}, 0);
      tick();
    end
    req1_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    chk("t4_released", rsp_valid, 0);
    chk("t4_idle", busy, 0);

    // 5: reset in the middle of a slow op.
    req1_valid = 1'b1; req1_op = ALU_SLT; req1_src1 = 32'h5; req1_src2 = 32'h9;
    alu_result = 32'h1;
    tick();
    req1_valid = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_alu_op", alu_op, 0);
    chk("t5_alu_src1", alu_src1, 0);
    chk("t5_rsp_valid", rsp_valid, 0);
    #1 rst_n = 1'b1;
    alu_slow_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_stale_rsp", rsp_valid, 0);
      chk("t5_no_stale_busy", busy, 0);
    end
    alu_slow_ready = 1'b0;

`ifdef ALU_SCHED_TIMEOUT_EN
    // 6: watchdog with slow_ready stuck low.
    req0_valid = 1'b1; req0_op = ALU_SLL; alu_result = 32'h55;
    tick();
    req0_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("t6_wait", rsp_valid, 0);
      tick();
    end
    tick();
    chk("t6_rsp_valid", rsp_valid, 1);
    chk("t6_timeout_err", timeout_err, 1);
    chk("t6_rsp_result", rsp_result, 0);
    tick();
    chk("t6_timeout_clear", timeout_err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
